// File: rtl/baser_block_lock_ctrl.sv
// Block-lock controller for the BASE-R 64B/66B receive path: sync-header
// based lock FSM with bit-slip request, checker gating and statistics.
module baser_block_lock_ctrl #(
  parameter int HDR_WIDTH    = 2,
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVLD_MAX = 16,
  parameter int SLIP_WAIT    = 2
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic [HDR_WIDTH-1:0] i_sh,
  input  logic                 i_clear_counts,
  output logic                 o_block_lock,
  output logic                 o_slip,
  output logic                 o_chk_enable,
  output logic [1:0]           o_state,
  output logic [31:0]          o_slip_count,
  output logic [31:0]          o_lock_loss_count
);

  typedef enum logic [1:0] {
    ST_HUNT      = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  localparam logic [6:0]  SH_CNT_MAX_C   = 7'(SH_CNT_MAX);
  localparam logic [4:0]  SH_INVLD_MAX_C = 5'(SH_INVLD_MAX);
  localparam logic [3:0]  SLIP_WAIT_C    = 4'(SLIP_WAIT);
  localparam logic [31:0] CNT_SAT        = 32'hFFFF_FFFF;

  state_t      r_state;
  logic [6:0]  r_sh_cnt;
  logic [4:0]  r_sh_invld_cnt;
  logic [3:0]  r_wait_cnt;
  logic        r_block_lock;
  logic        r_slip;
  logic [31:0] r_slip_count;
  logic [31:0] r_lock_loss_count;

  state_t      w_state_nxt;
  logic [6:0]  w_sh_cnt_nxt;
  logic [4:0]  w_sh_invld_cnt_nxt;
  logic [3:0]  w_wait_cnt_nxt;
  logic        w_block_lock_nxt;
  logic        w_slip_nxt;
  logic        w_slip_inc;
  logic        w_loss_inc;
  logic [31:0] w_slip_count_nxt;
  logic [31:0] w_lock_loss_count_nxt;

  logic        w_sh_valid;
  logic [6:0]  w_sh_cnt_inc;
  logic [4:0]  w_sh_invld_cnt_inc;

  // Only 01 and 10 are legal sync headers, i.e. the two bits differ.
  assign w_sh_valid         = i_sh[1] ^ i_sh[0];
  assign w_sh_cnt_inc       = r_sh_cnt + 7'd1;
  assign w_sh_invld_cnt_inc = r_sh_invld_cnt + {4'd0, ~w_sh_valid};

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latches).
  always_comb begin
    w_state_nxt        = r_state;
    w_sh_cnt_nxt       = r_sh_cnt;
    w_sh_invld_cnt_nxt = r_sh_invld_cnt;
    w_wait_cnt_nxt     = r_wait_cnt;
    w_block_lock_nxt   = r_block_lock;
    w_slip_nxt         = 1'b0;
    w_slip_inc         = 1'b0;
    w_loss_inc         = 1'b0;

    if (i_valid) begin
      unique case (r_state)
        ST_HUNT: begin
          if (w_sh_valid) begin
            if (w_sh_cnt_inc == SH_CNT_MAX_C) begin
              w_state_nxt        = ST_LOCKED;
              w_block_lock_nxt   = 1'b1;
              w_sh_cnt_nxt       = 7'd0;
              w_sh_invld_cnt_nxt = 5'd0;
            end else begin
              w_sh_cnt_nxt = w_sh_cnt_inc;
            end
          end else begin
            w_state_nxt    = ST_SLIP_WAIT;
            w_sh_cnt_nxt   = 7'd0;
            w_wait_cnt_nxt = SLIP_WAIT_C;
            w_slip_nxt     = 1'b1;
            w_slip_inc     = 1'b1;
          end
        end

        ST_SLIP_WAIT: begin
          // Header contents are meaningless until the aligner has settled.
          if (r_wait_cnt <= 4'd1) begin
            w_state_nxt    = ST_HUNT;
            w_wait_cnt_nxt = 4'd0;
            w_sh_cnt_nxt   = 7'd0;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt - 4'd1;
          end
        end

        ST_LOCKED: begin
          // Loss of lock is checked before window end so it wins a tie.
          if (w_sh_invld_cnt_inc == SH_INVLD_MAX_C) begin
            w_state_nxt        = ST_SLIP_WAIT;
            w_block_lock_nxt   = 1'b0;
            w_sh_cnt_nxt       = 7'd0;
            w_sh_invld_cnt_nxt = 5'd0;
            w_wait_cnt_nxt     = SLIP_WAIT_C;
            w_slip_nxt         = 1'b1;
            w_slip_inc         = 1'b1;
            w_loss_inc         = 1'b1;
          end else if (w_sh_cnt_inc == SH_CNT_MAX_C) begin
            w_sh_cnt_nxt       = 7'd0;
            w_sh_invld_cnt_nxt = 5'd0;
          end else begin
            w_sh_cnt_nxt       = w_sh_cnt_inc;
            w_sh_invld_cnt_nxt = w_sh_invld_cnt_inc;
          end
        end

        default: begin
          w_state_nxt        = ST_HUNT;
          w_block_lock_nxt   = 1'b0;
          w_sh_cnt_nxt       = 7'd0;
          w_sh_invld_cnt_nxt = 5'd0;
          w_wait_cnt_nxt     = 4'd0;
        end
      endcase
    end
  end

  // Statistics: clear beats increment, increments saturate at all-ones.
  always_comb begin
    w_slip_count_nxt      = r_slip_count;
    w_lock_loss_count_nxt = r_lock_loss_count;
    if (i_clear_counts) begin
      w_slip_count_nxt      = 32'd0;
      w_lock_loss_count_nxt = 32'd0;
    end else begin
      if (w_slip_inc && (r_slip_count != CNT_SAT)) begin
        w_slip_count_nxt = r_slip_count + 32'd1;
      end
      if (w_loss_inc && (r_lock_loss_count != CNT_SAT)) begin
        w_lock_loss_count_nxt = r_lock_loss_count + 32'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state           <= ST_HUNT;
      r_sh_cnt          <= 7'd0;
      r_sh_invld_cnt    <= 5'd0;
      r_wait_cnt        <= 4'd0;
      r_block_lock      <= 1'b0;
      r_slip            <= 1'b0;
      r_slip_count      <= 32'd0;
      r_lock_loss_count <= 32'd0;
    end else begin
      r_state           <= w_state_nxt;
      r_sh_cnt          <= w_sh_cnt_nxt;
      r_sh_invld_cnt    <= w_sh_invld_cnt_nxt;
      r_wait_cnt        <= w_wait_cnt_nxt;
      r_block_lock      <= w_block_lock_nxt;
      r_slip            <= w_slip_nxt;
      r_slip_count      <= w_slip_count_nxt;
      r_lock_loss_count <= w_lock_loss_count_nxt;
    end
  end

  assign o_block_lock      = r_block_lock;
  assign o_chk_enable      = r_block_lock;
  assign o_slip            = r_slip;
  assign o_state           = r_state;
  assign o_slip_count      = r_slip_count;
  assign o_lock_loss_count = r_lock_loss_count;

endmodule
